// File: rtl/buffer_uart_tx_pkg.sv
// Shared types and helpers for the buffer-to-UART transmitter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package buffer_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Ceiling log2 with a floor of 1 so that a counter always has at least one bit.
   function automatic int u_log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Total line time of one frame in clock cycles.
   function automatic int frame_len(input int data_width, input int clks_per_bit,
                                    input int stop_bits, input int parity_en);
      return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses o_bit_done on the last cycle of every CLKS_PER_BIT window.
// Latency: o_bit_done is combinational from the count; restart zeroes the count next edge.
// Backpressure: none; free-running between restarts.
//   i_clk      clock
//   i_rst_n    synchronous active-low reset
//   i_restart  begin a fresh bit period at the next edge
//   o_bit_done high on the final cycle of the current bit period
module uart_bit_timer
   import buffer_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   output logic o_bit_done
);

   localparam int TW = u_log2(CLKS_PER_BIT);

   logic [TW-1:0] cnt;

   assign o_bit_done = (cnt == TW'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_restart) begin
         cnt <= '0;
      end else if (o_bit_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TW'(1);
      end
   end

endmodule

// File: rtl/buffer_uart_tx.sv
// Pops words from the circular byte buffer and sends each as a UART frame (start, data LSB-first, opt. even parity, stop).
// Latency: pop strobe and start bit begin one edge after the launch condition; frames run back-to-back with no idle gap.
// Backpressure: launches only when i_enable=1 and the buffer is non-empty; a frame in flight always completes.
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_enable            permit new frames
//   i_data, i_data_size buffer head word and occupancy
//   o_read_en           one-cycle pop strobe to the buffer
//   o_tx, o_busy        serial line (idle high), frame-in-flight flag
//   o_frames_sent       wrapping count of completed frames
module buffer_uart_tx
   import buffer_uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [15:0]           i_data_size,
   output logic                  o_read_en,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic [15:0]           o_frames_sent
);

   // bit_idx walks data bits and is reused to count stop bits.
   localparam int BW = u_log2(DATA_WIDTH);

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0]         bit_idx, bit_idx_nxt;
   logic                  tx_nxt, busy_nxt, rd_nxt;
   logic                  load, frame_done, bit_done, launch;

   assign launch = i_enable && (i_data_size != 16'd0);

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_restart  (load),
      .o_bit_done (bit_done)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-output logic. o_tx is registered so the line is glitch-free;
   // shift_reg is held intact and bits are picked by index, so parity sees the whole word.
   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      tx_nxt      = o_tx;
      busy_nxt    = o_busy;
      rd_nxt      = 1'b0;
      load        = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
            if (launch) begin
               state_nxt = START;
               tx_nxt    = 1'b0;
               busy_nxt  = 1'b1;
               rd_nxt    = 1'b1;
               load      = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
               tx_nxt      = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == BW'(DATA_WIDTH - 1)) begin
                  bit_idx_nxt = '0;
                  if (PARITY_EN != 0) begin
                     state_nxt = PARITY;
                     tx_nxt    = ^shift_reg;
                  end else begin
                     state_nxt = STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  bit_idx_nxt = bit_idx + BW'(1);
                  tx_nxt      = shift_reg[bit_idx + BW'(1)];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_nxt   = STOP;
               bit_idx_nxt = '0;
               tx_nxt      = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (bit_idx == BW'(STOP_BITS - 1)) begin
                  frame_done  = 1'b1;
                  bit_idx_nxt = '0;
                  // Chain straight into the next frame when more data is waiting.
                  if (launch) begin
                     state_nxt = START;
                     tx_nxt    = 1'b0;
                     rd_nxt    = 1'b1;
                     load      = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                     busy_nxt  = 1'b0;
                  end
               end else begin
                  bit_idx_nxt = bit_idx + BW'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         bit_idx       <= '0;
         shift_reg     <= '0;
         o_tx          <= 1'b1;
         o_busy        <= 1'b0;
         o_read_en     <= 1'b0;
         o_frames_sent <= 16'd0;
      end else begin
         bit_idx   <= bit_idx_nxt;
         o_tx      <= tx_nxt;
         o_busy    <= busy_nxt;
         o_read_en <= rd_nxt;
         if (load) begin
            shift_reg <= i_data;
         end
         if (frame_done) begin
            o_frames_sent <= o_frames_sent + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Bench for buffer_uart_tx: two instances (8N1 and 8E2, 4 clocks per bit) fed by a modelled circular buffer.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_buffer_uart_tx;

   localparam int CLK = 4;

   logic        clk;
   logic        rst_n;
   logic [1:0]  en;
   logic [1:0]  rd;
   logic [1:0]  tx;
   logic [1:0]  busy;
   logic [7:0]  data [2];
   logic [15:0] size [2];
   logic [15:0] fs   [2];

   // Circular buffer model: tail moved only by the stimulus, head only by pops.
   logic [7:0]  buf_mem  [2][16];
   int          buf_head [2] = '{0, 0};
   int          buf_tail [2];
   int          model_fs [2];

   int checks = 0;
   int errors = 0;

   assign data[0] = buf_mem[0][4'(buf_head[0])];
   assign data[1] = buf_mem[1][4'(buf_head[1])];
   assign size[0] = 16'(buf_tail[0] - buf_head[0]);
   assign size[1] = 16'(buf_tail[1] - buf_head[1]);

   buffer_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CLK), .STOP_BITS(1), .PARITY_EN(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_data(data[0]), .i_data_size(size[0]),
      .o_read_en(rd[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_frames_sent(fs[0]));

   buffer_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CLK), .STOP_BITS(2), .PARITY_EN(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_data(data[1]), .i_data_size(size[1]),
      .o_read_en(rd[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_frames_sent(fs[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The buffer drops its head on the falling edge after a pop strobe.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rd[d] === 1'b1) buf_head[d] <= buf_head[d] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic [7:0] w);
      buf_mem[d][4'(buf_tail[d])] = w;
      buf_tail[d] = buf_tail[d] + 1;
   endtask

   // Builds the expected line waveform for nfr frames from the buffered words and checks
   // every cycle. drop_at / rst_at (-1 = unused) deassert enable or pulse reset before cycle i.
   // Called just after a falling edge with the launch condition already set up.
   task automatic run_frames(input string tag, input int d, input int nfr, input int tail_cycles,
                             input int drop_at, input int rst_at);
      logic [7:0] w;
      logic       exp_tx[$];
      logic       exp_rd[$];
      logic       exp_busy[$];
      int         exp_fs[$];
      int         fs_base;
      int         par;
      int         stops;
      par     = d;
      stops   = d + 1;
      fs_base = model_fs[d];
      for (int f = 0; f < nfr; f++) begin
         w = buf_mem[d][4'(buf_head[d] + f)];
         for (int k = 0; k < CLK; k++) begin
            exp_tx.push_back(1'b0); exp_rd.push_back(k == 0);
            exp_busy.push_back(1'b1); exp_fs.push_back(fs_base + f);
         end
         for (int b = 0; b < 8 + par + stops; b++) begin
            for (int k = 0; k < CLK; k++) begin
               if (b < 8) exp_tx.push_back(w[b]);
               else if (b == 8 && par == 1) exp_tx.push_back(^w);
               else exp_tx.push_back(1'b1);
               exp_rd.push_back(1'b0); exp_busy.push_back(1'b1); exp_fs.push_back(fs_base + f);
            end
         end
      end
      for (int k = 0; k < tail_cycles; k++) begin
         exp_tx.push_back(1'b1); exp_rd.push_back(1'b0);
         exp_busy.push_back(1'b0); exp_fs.push_back((fs_base + nfr) & 16'hFFFF);
      end
      model_fs[d] = (fs_base + nfr) & 16'hFFFF;
      for (int i = 0; i < exp_tx.size(); i++) begin
         if (i == drop_at) en[d] = 1'b0;
         if (i == rst_at) rst_n = 1'b0;
         @(posedge clk);
         #1;
         if (i == rst_at) begin
            rst_n = 1'b1;
            model_fs[0] = 0;
            model_fs[1] = 0;
         end
         if (rst_at >= 0 && i >= rst_at) begin
            exp_tx[i] = 1'b1; exp_rd[i] = 1'b0; exp_busy[i] = 1'b0; exp_fs[i] = 0;
         end
         chk($sformatf("%s_tx_c%0d", tag, i), tx[d], exp_tx[i]);
         chk($sformatf("%s_rd_c%0d", tag, i), rd[d], exp_rd[i]);
         chk($sformatf("%s_busy_c%0d", tag, i), busy[d], exp_busy[i]);
         chk($sformatf("%s_fs_c%0d", tag, i), fs[d], exp_fs[i]);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 2'b00;
      buf_tail[0] = 0;
      buf_tail[1] = 0;
      model_fs[0] = 0;
      model_fs[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_tx%0d", d), tx[d], 1'b1);
         chk($sformatf("reset_busy%0d", d), busy[d], 1'b0);
         chk($sformatf("reset_rd%0d", d), rd[d], 1'b0);
         chk($sformatf("reset_fs%0d", d), fs[d], 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single 8N1 frame of 0xA5: line 0,1,0,1,0,0,1,0,1,1.
      push(0, 8'hA5);
      en[0] = 1'b1;
      run_frames("a5_8n1", 0, 1, 3, -1, -1);
      chk("a5_8n1_count", fs[0], 16'd1);

      // 8E2: 0xA5 has parity 0, 0x07 has parity 1; sent back-to-back.
      push(1, 8'hA5);
      push(1, 8'h07);
      en[1] = 1'b1;
      run_frames("par_8e2", 1, 2, 3, -1, -1);

      // Three queued words go out with no idle gap.
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      run_frames("burst3", 0, 3, 3, -1, -1);

      // Empty buffer: no pop, line idle.
      run_frames("empty", 0, 0, 200, -1, -1);

      // Enable dropped during data bit 3: frame finishes, remaining words stay queued.
      for (int k = 0; k < 5; k++) push(0, 8'(8'h40 + k));
      run_frames("drop_en", 0, 1, 8, 4 * CLK, -1);
      chk("drop_en_left", size[0], 16'd4);
      buf_tail[0] = buf_head[0];

      // Reset during data bit 5 abandons the frame.
      push(0, 8'h5C);
      en[0] = 1'b1;
      run_frames("mid_rst", 0, 1, 4, -1, 6 * CLK + 1);
      chk("mid_rst_fs0", fs[0], 16'd0);
      chk("mid_rst_fs1", fs[1], 16'd0);

      // Random words and burst lengths on both instances.
      for (int r = 0; r < 8; r++) begin
         int d;
         int n;
         d = int'($urandom_range(0, 1));
         n = int'($urandom_range(1, 3));
         for (int k = 0; k < n; k++) push(d, 8'($urandom));
         en[d] = 1'b1;
         run_frames($sformatf("rand%0d", r), d, n, int'($urandom_range(1, 4)), -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
